clk_switch_ctrl: RTL and testbench

- Sequences the select line of the glitchless global clock mux (I0 = clk1, I1 = clk2).
- Accepts switch requests over a valid/ready handshake and confirms the target clock is running before it moves sel.
- After the switch, waits a settle period, then reports done; reports err if the target clock is dead.
- Runs in the muxed clock domain clko, in the clock-management area next to the mux.

---
 rtl/clk_sw_pkg.sv | 20 ++
 rtl/clk_activity_det.sv | 25 ++
 rtl/clk_switch_ctrl.sv | 64 ++++++
 tb/tb_clk_switch_ctrl.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/clk_sw_pkg.sv
// clk_sw_pkg: state encoding and default timing parameters for the clock-switch sequencer
package clk_sw_pkg;
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CHECK  = 3'd1,
    SWITCH = 3'd2,
    SETTLE = 3'd3,
    DONE   = 3'd4,
    ERR    = 3'd5
  } state_t;
  localparam int CHECK_WIN_D     = 64;
  localparam int MIN_EDGES_D     = 4;
  localparam int SETTLE_CYCLES_D = 16;
  function automatic int cnt_w(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    m = (m > c) ? m : c;
    return $clog2(m) + 1;
  endfunction
endpackage

// File: rtl/clk_activity_det.sv
// clk_activity_det: synchronizes a foreign-domain toggle and counts its edges, saturating at MIN_EDGES
module clk_activity_det #(
  parameter int MIN_EDGES = 4,
  parameter int W = 7
) (
  input  logic         clko,
  input  logic         rst,
  input  logic         tog,
  input  logic         clr,
  output logic [W-1:0] cnt
);
  logic [2:0] s;
  logic tog_edge;
  assign tog_edge = s[1] ^ s[2];
  always_ff @(posedge clko) begin
    if (rst) begin
      s   <= '0;
      cnt <= '0;
    end else begin
      s <= {s[1:0], tog};
      if (clr) cnt <= '0;
      else if (tog_edge && cnt != W'(MIN_EDGES)) cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/clk_switch_ctrl.sv
// clk_switch_ctrl: sequences the glitchless mux select, moving it only after the target clock
// proves alive, then waits a settle period before reporting done (or err if the target is dead).
module clk_switch_ctrl
  import clk_sw_pkg::*;
#(
  parameter int CHECK_WIN     = CHECK_WIN_D,
  parameter int MIN_EDGES     = MIN_EDGES_D,
  parameter int SETTLE_CYCLES = SETTLE_CYCLES_D
) (
  input  logic clko,
  input  logic rst,
  input  logic req_valid,
  input  logic req_sel,
  output logic req_ready,
  input  logic tog0,
  input  logic tog1,
  output logic sel,
  output logic busy,
  output logic done,
  output logic err
);
  localparam int W = cnt_w(CHECK_WIN, MIN_EDGES, SETTLE_CYCLES);
  state_t state, nxt;
  logic tgt, clr;
  logic [W-1:0] win, stl, ec0, ec1, ecs;
  assign clr       = state == IDLE;
  assign req_ready = state == IDLE;
  assign busy      = state != IDLE;
  assign done      = state == DONE;
  assign err       = state == ERR;
  assign ecs       = tgt ? ec1 : ec0;
  clk_activity_det #(.MIN_EDGES(MIN_EDGES), .W(W)) u_det0 (
    .clko(clko), .rst(rst), .tog(tog0), .clr(clr), .cnt(ec0)
  );
  clk_activity_det #(.MIN_EDGES(MIN_EDGES), .W(W)) u_det1 (
    .clko(clko), .rst(rst), .tog(tog1), .clr(clr), .cnt(ec1)
  );
  // liveness success takes priority over window expiry in the same cycle
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = !req_valid ? IDLE : (req_sel == sel) ? DONE : CHECK;
      CHECK:   nxt = (ecs == W'(MIN_EDGES)) ? SWITCH : (win == W'(CHECK_WIN - 1)) ? ERR : CHECK;
      SWITCH:  nxt = SETTLE;
      SETTLE:  nxt = (stl == W'(SETTLE_CYCLES - 1)) ? DONE : SETTLE;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clko) begin
    if (rst) begin
      state <= IDLE;
      sel   <= 1'b0;
      tgt   <= 1'b0;
      win   <= '0;
      stl   <= '0;
    end else begin
      state <= nxt;
      if (req_valid && req_ready) tgt <= req_sel;
      if (state == SWITCH) sel <= tgt;
      win <= (state == CHECK) ? win + 1'b1 : '0;
      stl <= (state == SETTLE) ? stl + 1'b1 : '0;
    end
  end
endmodule

// File: tb/tb_clk_switch_ctrl.sv
// tb_clk_switch_ctrl: directed sequence with a pulse scoreboard (kind, arrival cycle, sel at pulse)
module tb_clk_switch_ctrl;
  logic clko = 1'b0;
  logic rst, req_valid, req_sel, tog0, tog1;
  logic req_ready, sel, busy, done, err;
  int cyc = 0;
  int chk = 0;
  int errs = 0;
  logic run0 = 1'b0;
  logic run1 = 1'b0;
  int base0 = 0;
  int base1 = 0;
  typedef struct {int at; logic [1:0] kind; logic sel;} exp_t;
  exp_t q[$];
  localparam logic [1:0] K_DONE = 2'b01;
  localparam logic [1:0] K_ERR  = 2'b10;

  clk_switch_ctrl dut (
    .clko(clko), .rst(rst), .req_valid(req_valid), .req_sel(req_sel), .req_ready(req_ready),
    .tog0(tog0), .tog1(tog1), .sel(sel), .busy(busy), .done(done), .err(err)
  );

  always #5 clko = ~clko;
  always @(posedge clko) cyc <= cyc + 1;

  // toggles flip every 3 clko cycles, first flip on the negedge where cyc == base
  always @(negedge clko) begin
    tog0 = (run0 && cyc >= base0) ? (((cyc - base0) / 3) % 2 == 0) : 1'b0;
    tog1 = (run1 && cyc >= base1) ? (((cyc - base1) / 3) % 2 == 0) : 1'b0;
  end

  task automatic check(input string tag, input int obs, input int exp);
    chk++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  always @(negedge clko) begin
    if (done || err) begin
      check("pulse_exclusive", int'(done & err), 0);
      if (q.size() == 0) check("spurious_pulse", int'({err, done}), 0);
      else begin
        exp_t e;
        e = q.pop_front();
        check("pulse_kind", int'({err, done}), int'(e.kind));
        check("pulse_cycle", cyc, e.at);
        check("pulse_sel", int'(sel), int'(e.sel));
      end
    end
  end

  // issues a request at the current negedge; returns at the first negedge after the accept edge
  task automatic request(input logic s, input logic [1:0] kind, input int lat, input logic sel_exp);
    exp_t e;
    check("req_ready_idle", int'(req_ready), 1);
    if (kind != 2'b00) begin
      e.at = cyc + lat;
      e.kind = kind;
      e.sel = sel_exp;
      q.push_back(e);
    end
    req_valid = 1'b1;
    req_sel = s;
    @(negedge clko);
    req_valid = 1'b0;
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && q.size() != 0; i++) @(negedge clko);
    check("sb_drain", q.size(), 0);
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 1'b0;
    req_sel = 1'b0;
    repeat (2) @(negedge clko);
    check("rst_sel", int'(sel), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_ready", int'(req_ready), 1);
    check("rst_done", int'(done), 0);
    check("rst_err", int'(err), 0);
    rst = 1'b0;
    @(negedge clko);
    // no-op request
    request(1'b0, K_DONE, 1, 1'b0);
    check("noop_busy", int'(busy), 1);
    @(negedge clko);
    check("noop_busy_clr", int'(busy), 0);
    drain(5);
    // dead target
    request(1'b1, K_ERR, 65, 1'b0);
    drain(100);
    check("dead_sel", int'(sel), 0);
    // good switch to clk2 with an ignored request during settle
    base1 = cyc + 1;
    run1 = 1'b1;
    request(1'b1, K_DONE, 31, 1'b1);
    repeat (13) @(negedge clko);
    check("sw_sel_before", int'(sel), 0);
    check("sw_busy_check", int'(busy), 1);
    @(negedge clko);
    check("sw_sel_after", int'(sel), 1);
    repeat (5) @(negedge clko);
    req_valid = 1'b1;
    req_sel = 1'b0;
    repeat (4) begin
      @(negedge clko);
      check("settle_ready", int'(req_ready), 0);
      check("settle_busy", int'(busy), 1);
    end
    req_valid = 1'b0;
    drain(40);
    @(negedge clko);
    check("sw_sel_final", int'(sel), 1);
    check("sw_ready_final", int'(req_ready), 1);
    run1 = 1'b0;
    repeat (6) @(negedge clko);
    check("sw_no_extra", q.size(), 0);
    // good switch back to clk1
    base0 = cyc + 1;
    run0 = 1'b1;
    request(1'b0, K_DONE, 31, 1'b0);
    drain(40);
    run0 = 1'b0;
    repeat (6) @(negedge clko);
    check("back_sel", int'(sel), 0);
    // reset during settle with sel already moved
    base1 = cyc + 1;
    run1 = 1'b1;
    request(1'b1, 2'b00, 0, 1'b0);
    repeat (19) @(negedge clko);
    check("mid_sel_moved", int'(sel), 1);
    check("mid_busy", int'(busy), 1);
    rst = 1'b1;
    @(negedge clko);
    rst = 1'b0;
    check("mid_rst_sel", int'(sel), 0);
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_ready", int'(req_ready), 1);
    check("mid_rst_done", int'(done), 0);
    check("mid_rst_err", int'(err), 0);
    run1 = 1'b0;
    repeat (30) @(negedge clko);
    check("mid_sel_stays", int'(sel), 0);
    $display("Simulation finished: %0d checks, %0d errors", chk, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
